// File: rtl/bmp_row_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_row_packer_pkg
// Description : Shared constants and the packer frame FSM state encoding for
//               the BMP frame-capture writer.
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_row_packer_pkg;

  // Pixel stream width ({R,G,B}, B in [7:0]) and frame-memory word width
  localparam int PIXEL_SIZE = 24;
  localparam int WORD_SIZE  = 32;

  // Frame FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rgb_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : rgb_word_packer
// Description : Byte accumulator that packs 24-bit pixels into 32-bit words
//               in BMP byte order and produces the zero-padded row-end word.
// Ports       : clk, reset        - clock, async active-high reset
//               accept_i          - pixel accepted this cycle
//               row_end_i         - accepted pixel is the last of its row
//               pixel_i[23:0]     - pixel, byte0 = [7:0]
//               write_o           - a word is produced this cycle
//               word_o[31:0]      - produced word, byte0 = [7:0]
//               flush_next_o      - row end leaves bytes; flush word follows
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_word_packer
  import bmp_row_packer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept_i,
  input  logic                  row_end_i,
  input  logic [PIXEL_SIZE-1:0] pixel_i,
  output logic                  write_o,
  output logic [WORD_SIZE-1:0]  word_o,
  output logic                  flush_next_o
);

  logic [1:0]            held_q, held_d;
  logic [PIXEL_SIZE-1:0] acc_q, acc_d;          // held bytes, LSB-aligned
  logic                  flush_pend_q, flush_pend_d;
  logic [WORD_SIZE-1:0]  flush_word_q, flush_word_d;

  logic                  acc_write;
  logic [WORD_SIZE-1:0]  acc_word;
  logic [WORD_SIZE-1:0]  leftover;
  logic                  left_any;

  always_comb begin
    held_d       = held_q;
    acc_d        = acc_q;
    flush_pend_d = 1'b0;
    flush_word_d = flush_word_q;
    acc_write    = 1'b0;
    acc_word     = '0;
    leftover     = '0;
    left_any     = 1'b0;

    if (accept_i) begin
      case (held_q)
        2'd0: begin
          acc_d    = pixel_i;
          held_d   = 2'd3;
          leftover = {8'h00, pixel_i};
          left_any = 1'b1;
        end
        2'd3: begin
          acc_write = 1'b1;
          acc_word  = {pixel_i[7:0], acc_q[23:0]};
          acc_d     = {8'h00, pixel_i[23:8]};
          held_d    = 2'd2;
          leftover  = {16'h0000, pixel_i[23:8]};
          left_any  = 1'b1;
        end
        2'd2: begin
          acc_write = 1'b1;
          acc_word  = {pixel_i[15:0], acc_q[15:0]};
          acc_d     = {16'h0000, pixel_i[23:16]};
          held_d    = 2'd1;
          leftover  = {24'h000000, pixel_i[23:16]};
          left_any  = 1'b1;
        end
        default: begin
          acc_write = 1'b1;
          acc_word  = {pixel_i, acc_q[7:0]};
          held_d    = 2'd0;
        end
      endcase

      // Row end: remaining bytes move to the flush register so the next
      // row's first pixel (which never writes) can load the accumulator in
      // the same cycle the flush word goes out.
      if (row_end_i) begin
        held_d       = 2'd0;
        flush_pend_d = left_any;
        flush_word_d = leftover;
      end
    end
  end

  // A pending flush and an accumulator write can never coincide: the
  // accepted pixel in the flush cycle always starts from held=0.
  assign write_o      = flush_pend_q | acc_write;
  assign word_o       = flush_pend_q ? flush_word_q : acc_word;
  assign flush_next_o = accept_i & row_end_i & left_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q       <= 2'd0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_word_q <= '0;
    end else begin
      held_q       <= held_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      flush_word_q <= flush_word_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bmp_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : bmp_row_packer
// Description : Frame-capture writer; packs the 24-bit pixel stream into a
//               32-bit frame memory in BMP byte order with each row padded
//               to a 4-byte boundary.
// Ports       : clk, reset               - clock, async active-high reset
//               start, width, height,    - arm a frame (IDLE only)
//               base_addr
//               en, data                 - pixel stream
//               wr_en, wr_addr, wr_data  - registered memory write port
//               busy, frame_done         - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_row_packer #(
  parameter int PIXEL_SIZE = 24,
  parameter int MEM_WORD   = 32,
  parameter int ADDR_W     = 20,
  parameter int DIM_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_W-1:0]      width,
  input  logic [DIM_W-1:0]      height,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  en,
  input  logic [PIXEL_SIZE-1:0] data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [MEM_WORD-1:0]   wr_data,
  output logic                  busy,
  output logic                  frame_done
);
  import bmp_row_packer_pkg::*;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    width_q, width_d;
  logic [DIM_W-1:0]    height_q, height_d;
  logic [DIM_W-1:0]    pix_q, pix_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, frame_done_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [MEM_WORD-1:0] wr_data_q;

  logic                accept;
  logic                row_end;
  logic                pk_write;
  logic [MEM_WORD-1:0] pk_word;
  logic                pk_flush_next;

  assign accept  = (state_q == S_RUN) && en;
  assign row_end = (pix_q == width_q - DIM_W'(1));

  rgb_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .accept_i     (accept),
    .row_end_i    (row_end),
    .pixel_i      (data),
    .write_o      (pk_write),
    .word_o       (pk_word),
    .flush_next_o (pk_flush_next)
  );

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    pix_d    = pix_q;
    row_d    = row_q;
    addr_d   = addr_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          width_d  = width;
          height_d = height;
          addr_d   = base_addr;
          pix_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = (width == '0 || height == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (row_end) begin
            pix_d = '0;
            if (row_q == height_q - DIM_W'(1)) begin
              state_d = pk_flush_next ? S_FLUSH : S_DONE;
            end else begin
              row_d = row_q + DIM_W'(1);
            end
          end else begin
            pix_d = pix_q + DIM_W'(1);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Writes never occur in IDLE, so this cannot clash with the base load.
    if (pk_write) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      pix_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      pix_q        <= pix_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      wr_en_q      <= pk_write;
      frame_done_q <= (state_q == S_DONE);
      if (pk_write) begin
        wr_addr_q <= addr_q;
        wr_data_q <= pk_word;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bmp_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_row_packer
// Description : Scoreboard bench for bmp_row_packer; directed frames push
//               expected writes / frame_done events, a negedge monitor pops
//               and compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_row_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [19:0] base_addr;
  logic        en;
  logic [23:0] data;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_done;
    bit          need_prev;
    logic [19:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic prev_wr = 1'b0;

  always #5 clk = ~clk;

  bmp_row_packer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .width      (width),
    .height     (height),
    .base_addr  (base_addr),
    .en         (en),
    .data       (data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%h data=%h, none expected", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done || e.addr !== wr_addr || e.data !== wr_data) begin
            failures++;
            $display("FAIL write got addr=%h data=%h, expected is_done=%0d addr=%h data=%h",
                     wr_addr, wr_data, e.is_done, e.addr, e.data);
          end
        end
      end
      if (frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame_done got frame_done=1, none expected");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done || (e.need_prev && !prev_wr)) begin
            failures++;
            $display("FAIL frame_done got frame_done=1 prev_wr=%0d, expected is_done=%0d need_prev_wr=%0d",
                     prev_wr, e.is_done, e.need_prev);
          end
        end
      end
    end
    prev_wr = wr_en;
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic exp_wr(input logic [19:0] a, input logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0; e.need_prev = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input bit need_prev);
    exp_t e;
    e.is_done = 1'b1; e.need_prev = need_prev; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] w, input logic [15:0] h, input logic [19:0] b);
    start = 1'b1; width = w; height = h; base_addr = b;
    tick();
    start = 1'b0; width = 16'h00ff; height = 16'h00ff; base_addr = 20'hfffff;
  endtask

  task automatic pix(input logic [23:0] p, input int stall);
    en = 1'b1; data = p;
    tick();
    en = 1'b0; data = 24'hEEEEEE;   // junk while idle must be ignored
    repeat (stall) tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending events, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Four-pixel single-row frame; optional stall cycles and a stray start.
  task automatic frame_case1(input logic [19:0] b, input int stall, input bit stray_start);
    exp_wr(b,            32'h04030201);
    exp_wr(b + 20'd1,    32'h08070605);
    exp_wr(b + 20'd2,    32'h0C0B0A09);
    exp_done(1'b1);
    do_start(16'd4, 16'd1, b);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    pix(24'h030201, stall);
    if (stray_start) begin
      start = 1'b1; width = 16'd7; height = 16'd3; base_addr = 20'h00099;
      tick();
      start = 1'b0;
    end
    pix(24'h060504, stall);
    pix(24'h090807, stall);
    pix(24'h0C0B0A, stall);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1; start = 1'b0; width = '0; height = '0; base_addr = '0;
    en = 1'b0; data = '0;
    @(negedge clk);
    chk("rst_wr_en",      {31'b0, wr_en},      32'd0);
    chk("rst_wr_addr",    {12'b0, wr_addr},    32'd0);
    chk("rst_wr_data",    wr_data,             32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Case 1: width 4, exact word alignment, no flush
    frame_case1(20'h00010, 0, 1'b0);
    drain("case1");
    chk("case1_busy_end", {31'b0, busy}, 32'd0);

    // Case 2: width 3, one trailing byte flushed
    exp_wr(20'h00000, 32'h04030201);
    exp_wr(20'h00001, 32'h08070605);
    exp_wr(20'h00002, 32'h00000009);
    exp_done(1'b1);
    do_start(16'd3, 16'd1, 20'h00000);
    pix(24'h030201, 0);
    pix(24'h060504, 0);
    pix(24'h090807, 0);
    drain("case2");

    // Case 3: width 1, two rows back-to-back, each row is a flush word
    exp_wr(20'h00000, 32'h00AABBCC);
    exp_wr(20'h00001, 32'h00112233);
    exp_done(1'b1);
    do_start(16'd1, 16'd2, 20'h00000);
    pix(24'hAABBCC, 0);
    pix(24'h112233, 0);
    drain("case3");

    // Case 4: case 1 with 2-cycle stalls and a start pulse during RUN
    frame_case1(20'h00010, 2, 1'b1);
    drain("case4");

    // Case 5: reset after two pixels of a width-4 frame
    exp_wr(20'h00020, 32'h04030201);
    do_start(16'd4, 16'd1, 20'h00020);
    pix(24'h030201, 0);
    pix(24'h060504, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("midrst_busy",  {31'b0, busy},  32'd0);
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("midrst_pending", exp_q.size(), 32'd0);
    chk("midrst_idle_busy", {31'b0, busy}, 32'd0);
    frame_case1(20'h00030, 0, 1'b0);
    drain("case5_restart");

    // Case 6: zero width -> no writes, frame_done one cycle after start
    exp_done(1'b0);
    do_start(16'd0, 16'd5, 20'h00050);
    chk("zero_done_early", {31'b0, frame_done}, 32'd0);
    chk("zero_busy",       {31'b0, busy},       32'd1);
    tick();
    chk("zero_done",       {31'b0, frame_done}, 32'd1);
    chk("zero_busy_end",   {31'b0, busy},       32'd0);
    tick();
    chk("zero_done_pulse", {31'b0, frame_done}, 32'd0);
    drain("case6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
